// File: rtl/line_buffer_window_if.sv
// Pixel-side and kernel-side signal bundle for the single-line window buffer.
// The master drives pixels, read requests and flag clears; the slave is the buffer.
interface line_buffer_window_if #(
    parameter int DATA_W   = 8,
    parameter int TAPS     = 3,
    parameter int LINE_LEN = 640
);
    localparam int CNT_W = $clog2(LINE_LEN + 1);

    logic [DATA_W-1:0]      i_data;
    logic                   i_data_valid;
    logic                   o_wr_ready;
    logic                   i_rd_data;
    logic                   o_rd_ready;
    logic [TAPS*DATA_W-1:0] o_data;
    logic                   o_data_valid;
    logic [CNT_W-1:0]       o_count;
    logic                   o_line_ready;
    logic                   i_clr_flags;
    logic                   o_overflow;
    logic                   o_underflow;

    modport master (
        output i_data, i_data_valid, i_rd_data, i_clr_flags,
        input  o_wr_ready, o_rd_ready, o_data, o_data_valid, o_count,
               o_line_ready, o_overflow, o_underflow
    );

    modport slave (
        input  i_data, i_data_valid, i_rd_data, i_clr_flags,
        output o_wr_ready, o_rd_ready, o_data, o_data_valid, o_count,
               o_line_ready, o_overflow, o_underflow
    );
endinterface

// File: rtl/line_buffer_window.sv
// Single-line circular pixel buffer emitting a registered horizontal window of
// TAPS pixels per read. Taps past the end of the line never wrap into the next
// line; they take either the last pixel of the line or zero (EDGE_MODE).
module line_buffer_window #(
    parameter int DATA_W    = 8,
    parameter int LINE_LEN  = 640,
    parameter int TAPS      = 3,
    parameter int EDGE_MODE = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    line_buffer_window_if.slave   bus
);
    localparam int ADDR_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int CNT_W  = $clog2(LINE_LEN + 1);
    localparam int IDX_W  = CNT_W + 1;
    localparam int WIN_W  = TAPS * DATA_W;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_LEN - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(LINE_LEN);
    localparam logic [CNT_W-1:0]  TAPS_CNT  = CNT_W'(TAPS);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_LEN - 1);

    logic [DATA_W-1:0] mem_q [LINE_LEN];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WIN_W-1:0]  data_q, data_d;
    logic              data_valid_q, data_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic [CNT_W-1:0]  remain_s;
    logic [CNT_W-1:0]  need_s;
    logic              rd_ready_s;
    logic              wr_ready_s;
    logic              rd_ok_s;
    logic              wr_ok_s;
    logic [IDX_W-1:0]  idx_s;
    logic [WIN_W-1:0]  window_s;

    // Readiness depends only on registered pointers/occupancy; a read near the end of line needs fewer stored pixels
    always_comb begin
        remain_s = FULL_CNT - CNT_W'(rd_ptr_q);
        if (remain_s < TAPS_CNT) begin
            need_s = remain_s;
        end else begin
            need_s = TAPS_CNT;
        end
        rd_ready_s = (count_q >= need_s);
        wr_ready_s = (count_q < FULL_CNT);
    end

    // Accepted transfers; a full buffer still takes a pixel when a read frees a slot in the same cycle
    always_comb begin
        rd_ok_s = bus.i_rd_data && rd_ready_s;
        wr_ok_s = bus.i_data_valid && (wr_ready_s || rd_ok_s);
    end

    // Gather the window from pre-edge RAM contents so a same-slot write returns old data
    always_comb begin
        window_s = {WIN_W{1'b0}};
        idx_s    = {IDX_W{1'b0}};
        for (int k = 0; k < TAPS; k++) begin
            idx_s = IDX_W'(rd_ptr_q) + IDX_W'(k);
            if (idx_s <= LAST_IDX) begin
                window_s[(TAPS-1-k)*DATA_W +: DATA_W] = mem_q[idx_s[ADDR_W-1:0]];
            end else if (EDGE_MODE == 0) begin
                window_s[(TAPS-1-k)*DATA_W +: DATA_W] = mem_q[LAST_ADDR];
            end else begin
                window_s[(TAPS-1-k)*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            end
        end
    end

    // Next state: pointers wrap at LINE_LEN-1, occupancy tracks net transfers, sticky flags with set priority
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;

        if (wr_ok_s) begin
            wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? ADDR_ZERO : wr_ptr_q + ADDR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_ok_s) begin
            rd_ptr_d     = (rd_ptr_q == LAST_ADDR) ? ADDR_ZERO : rd_ptr_q + ADDR_ONE;
            data_d       = window_s;
            data_valid_d = 1'b1;
        end else begin
            rd_ptr_d     = rd_ptr_q;
            data_d       = data_q;
            data_valid_d = 1'b0;
        end

        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (bus.i_data_valid && !wr_ok_s) begin
            overflow_d = 1'b1;
        end else if (bus.i_clr_flags) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (bus.i_rd_data && !rd_ok_s) begin
            underflow_d = 1'b1;
        end else if (bus.i_clr_flags) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Control and output registers; reset discards all state including a pending valid pulse
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q     <= ADDR_ZERO;
            rd_ptr_q     <= ADDR_ZERO;
            count_q      <= {CNT_W{1'b0}};
            data_q       <= {WIN_W{1'b0}};
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Line storage; contents deliberately survive reset
    always_ff @(posedge i_clk) begin
        if (wr_ok_s) begin
            mem_q[wr_ptr_q] <= bus.i_data;
        end
    end

    assign bus.o_wr_ready   = wr_ready_s;
    assign bus.o_rd_ready   = rd_ready_s;
    assign bus.o_count      = count_q;
    assign bus.o_line_ready = (count_q == FULL_CNT);
    assign bus.o_data       = data_q;
    assign bus.o_data_valid = data_valid_q;
    assign bus.o_overflow   = overflow_q;
    assign bus.o_underflow  = underflow_q;

endmodule

// File: tb/tb_line_buffer_window.sv
// Bench for line_buffer_window: two instances (replicate and zero edge modes)
// share one stimulus stream; a queue-free array model of the line tracks the
// expected outputs and is checked every cycle, with directed literal checks.
module tb_line_buffer_window;
    localparam int W = 8;
    localparam int L = 8;
    localparam int T = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       drv_wr   = 1'b0;
    logic       drv_rd   = 1'b0;
    logic       drv_clr  = 1'b0;
    logic [7:0] drv_data = 8'h00;
    bit         chk_en   = 1'b0;

    int vecs = 0;
    int errs = 0;

    line_buffer_window_if #(.DATA_W(W), .TAPS(T), .LINE_LEN(L)) if0 ();
    line_buffer_window_if #(.DATA_W(W), .TAPS(T), .LINE_LEN(L)) if1 ();

    assign if0.i_data       = drv_data;
    assign if0.i_data_valid = drv_wr;
    assign if0.i_rd_data    = drv_rd;
    assign if0.i_clr_flags  = drv_clr;
    assign if1.i_data       = drv_data;
    assign if1.i_data_valid = drv_wr;
    assign if1.i_rd_data    = drv_rd;
    assign if1.i_clr_flags  = drv_clr;

    line_buffer_window #(.DATA_W(W), .LINE_LEN(L), .TAPS(T), .EDGE_MODE(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .bus(if0.slave));
    line_buffer_window #(.DATA_W(W), .LINE_LEN(L), .TAPS(T), .EDGE_MODE(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .bus(if1.slave));

    // ---------------- behavioural model ----------------
    int          m_mem [L];
    int          m_wr, m_rd, m_cnt;
    logic [23:0] m_d0, m_d1;
    bit          m_v, m_ovf, m_udf;
    int          m_need;
    bit          m_rdy, m_rok, m_wok;

    always_comb begin
        m_need = ((L - m_rd) < T) ? (L - m_rd) : T;
        m_rdy  = (m_cnt >= m_need);
        m_rok  = drv_rd && m_rdy;
        m_wok  = drv_wr && ((m_cnt < L) || m_rok);
    end

    function automatic logic [23:0] window(input int mode);
        logic [23:0] w;
        int p, t;
        w = 24'h0;
        for (int k = 0; k < T; k++) begin
            p = m_rd + k;
            if (p < L) t = m_mem[p];
            else if (mode == 0) t = m_mem[L-1];
            else t = 0;
            w = (w << W) | 24'(t & 8'hFF);
        end
        return w;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wr <= 0; m_rd <= 0; m_cnt <= 0;
            m_d0 <= 24'h0; m_d1 <= 24'h0;
            m_v <= 1'b0; m_ovf <= 1'b0; m_udf <= 1'b0;
        end else begin
            if (m_wok) begin
                m_mem[m_wr] <= int'(drv_data);
                m_wr <= (m_wr + 1) % L;
            end
            if (m_rok) begin
                m_d0 <= window(0);
                m_d1 <= window(1);
                m_rd <= (m_rd + 1) % L;
            end
            m_v   <= m_rok;
            m_cnt <= m_cnt + int'(m_wok) - int'(m_rok);
            if (drv_wr && !m_wok) m_ovf <= 1'b1;
            else if (drv_clr) m_ovf <= 1'b0;
            if (drv_rd && !m_rok) m_udf <= 1'b1;
            else if (drv_clr) m_udf <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("data_e0",    64'(if0.o_data),       64'(m_d0));
            check("data_e1",    64'(if1.o_data),       64'(m_d1));
            check("valid_e0",   64'(if0.o_data_valid), 64'(m_v));
            check("valid_e1",   64'(if1.o_data_valid), 64'(m_v));
            check("count",      64'(if0.o_count),      64'(m_cnt));
            check("count_e1",   64'(if1.o_count),      64'(m_cnt));
            check("wr_ready",   64'(if0.o_wr_ready),   64'(m_cnt < L));
            check("rd_ready",   64'(if0.o_rd_ready),   64'(m_rdy));
            check("line_ready", 64'(if0.o_line_ready), 64'(m_cnt == L));
            check("overflow",   64'(if0.o_overflow),   64'(m_ovf));
            check("underflow",  64'(if0.o_underflow),  64'(m_udf));
        end
    end

    // One clock of stimulus; inputs change 1 time unit after the rising edge
    task automatic cyc(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
        drv_wr = wr; drv_data = d; drv_rd = rd; drv_clr = clr;
        @(posedge clk);
        #1;
        drv_wr = 1'b0; drv_rd = 1'b0; drv_clr = 1'b0; drv_data = 8'h00;
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int pw, pr;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // 1. asynchronous reset mid-cycle with a valid pulse showing
        cyc(1'b1, 8'h01, 1'b0, 1'b0);
        cyc(1'b1, 8'h02, 1'b0, 1'b0);
        cyc(1'b1, 8'h03, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("pre_rst_data", 64'(if0.o_data), 64'h010203);
        #1 rst = 1'b1;
        #1;
        check("rst_data",     64'(if0.o_data),       64'h0);
        check("rst_valid",    64'(if0.o_data_valid), 64'h0);
        check("rst_count",    64'(if0.o_count),      64'h0);
        check("rst_wr_ready", 64'(if0.o_wr_ready),   64'h1);
        check("rst_rd_ready", 64'(if0.o_rd_ready),   64'h0);
        check("rst_line_rdy", 64'(if0.o_line_ready), 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 2. fill and first window
        for (int i = 0; i < L; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        check("fill_count",    64'(if0.o_count),      64'd8);
        check("fill_line_rdy", 64'(if0.o_line_ready), 64'h1);
        check("fill_wr_ready", 64'(if0.o_wr_ready),   64'h0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("win0_data",  64'(if0.o_data),       64'h101112);
        check("win0_valid", 64'(if0.o_data_valid), 64'h1);
        check("win0_count", 64'(if0.o_count),      64'd7);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("win0_pulse", 64'(if0.o_data_valid), 64'h0);
        check("win0_hold",  64'(if0.o_data),       64'h101112);

        // 3. end-of-line edge handling in both modes
        repeat (4) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("edge5_e0", 64'(if0.o_data), 64'h151617);
        check("edge5_e1", 64'(if1.o_data), 64'h151617);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("edge6_e0", 64'(if0.o_data), 64'h161717);
        check("edge6_e1", 64'(if1.o_data), 64'h161700);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("edge7_e0", 64'(if0.o_data), 64'h171717);
        check("edge7_e1", 64'(if1.o_data), 64'h170000);
        check("edge_empty", 64'(if0.o_count), 64'd0);

        // 4. full buffer with simultaneous read and write to the same slot
        for (int i = 0; i < L; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'hAA, 1'b1, 1'b0);
        check("rdw_data",  64'(if0.o_data),     64'h101112);
        check("rdw_count", 64'(if0.o_count),    64'd8);
        check("rdw_ovf",   64'(if0.o_overflow), 64'h0);
        repeat (7) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 8'hB1, 1'b0, 1'b0);
        cyc(1'b1, 8'hB2, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("rdw_newslot", 64'(if0.o_data), 64'hAAB1B2);

        // 5. error flags
        do_reset();
        cyc(1'b1, 8'h20, 1'b0, 1'b0);
        cyc(1'b1, 8'h21, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("udf_flag",  64'(if0.o_underflow),  64'h1);
        check("udf_valid", 64'(if0.o_data_valid), 64'h0);
        check("udf_count", 64'(if0.o_count),      64'd2);
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        check("udf_setwins", 64'(if0.o_underflow), 64'h1);
        for (int i = 2; i < L; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0);
        check("ovf_flag",  64'(if0.o_overflow), 64'h1);
        check("ovf_count", 64'(if0.o_count),    64'd8);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("clr_ovf", 64'(if0.o_overflow),  64'h0);
        check("clr_udf", 64'(if0.o_underflow), 64'h0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("ovf_dropped", 64'(if0.o_data), 64'h202122);

        // 6. reset between a read request and its valid cycle
        drv_rd = 1'b1;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        drv_rd = 1'b0;
        check("rst_squash_valid", 64'(if0.o_data_valid), 64'h0);
        check("rst_squash_count", 64'(if0.o_count),      64'd0);
        rst = 1'b0;
        cyc(1'b1, 8'h40, 1'b0, 1'b0);
        cyc(1'b1, 8'h41, 1'b0, 1'b0);
        cyc(1'b1, 8'h42, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("refill_slot0", 64'(if0.o_data), 64'h404142);

        // randomized streaming with varying fill/drain pressure
        for (int ph = 0; ph < 15; ph++) begin
            pw = $urandom_range(10, 90);
            pr = $urandom_range(10, 90);
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 499) == 0) do_reset();
                else cyc($urandom_range(0, 99) < pw, 8'($urandom),
                         $urandom_range(0, 99) < pr, $urandom_range(0, 39) == 0);
            end
        end

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/line_buffer_window.md
Name: line_buffer_window

Overview:
Parametrised single-line pixel buffer for the image-processing pipeline. It sits between the pixel source and the convolution or kernel stage. It stores one image line in a circular RAM and, on each read, emits a registered horizontal window of TAPS consecutive pixels. It tracks occupancy, so the kernel control can stack several instances to form an N-line vertical window. Compared with the fixed 640x8-bit, 3-tap buffer it generalises width, length and tap count, and adds flow control, defined end-of-line edge handling and error flags.

Parameters:
DATA_W, 8, bits per pixel
LINE_LEN, 640, pixels per line; RAM depth (>= TAPS)
TAPS, 3, window width in pixels (1..8)
EDGE_MODE, 0, out-of-line tap value: 0 = replicate last pixel of line, 1 = zero
(derived, not overridable: ADDR_W = clog2(LINE_LEN), CNT_W = clog2(LINE_LEN+1))

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst  in  1  reset, asynchronous, active-high
i_data  in  DATA_W  write pixel
i_data_valid  in  1  write request
o_wr_ready  out  1  count < LINE_LEN
i_rd_data  in  1  read request: emit window at rdPntr, then advance rdPntr by 1
o_rd_ready  out  1  full window for current rdPntr is present
o_data  out  TAPS*DATA_W  window; tap 0 (pixel at rdPntr) in MSBs, tap TAPS-1 in LSBs
o_data_valid  out  1  one-cycle pulse, o_data updated
o_count  out  CNT_W  pixels currently stored
o_line_ready  out  1  count == LINE_LEN
i_clr_flags  in  1  synchronous clear of sticky flags
o_overflow  out  1  sticky: write requested while not accepted
o_underflow  out  1  sticky: read requested while o_rd_ready low

Behaviour:
- Reset (async assert, sync-safe deassert):
  - wrPntr, rdPntr, count = 0.
  - o_data = 0; o_data_valid, o_overflow, o_underflow = 0.
  - RAM contents are not reset.
- Pointers: wrPntr and rdPntr range 0..LINE_LEN-1 and wrap LINE_LEN-1 -> 0; no power-of-two assumption.
- rd_ok = i_rd_data && o_rd_ready.
  - need = min(TAPS, LINE_LEN - rdPntr).
  - o_rd_ready = (count >= need).
- wr_ok = i_data_valid && (count < LINE_LEN || rd_ok).
  - A write is accepted when the buffer is full only if a read is accepted in the same cycle.
- Count:
  - +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither.
  - Never exceeds LINE_LEN and never goes below 0.
- Write: on wr_ok, RAM[wrPntr] <= i_data and wrPntr advances.
- Read, latency 1:
  - On rd_ok, o_data is loaded next edge with taps k = 0..TAPS-1.
  - Tap k = RAM[rdPntr+k] when rdPntr+k <= LINE_LEN-1.
  - Otherwise tap k = RAM[LINE_LEN-1] (EDGE_MODE 0) or 0 (EDGE_MODE 1).
  - Taps never wrap into the next line. rdPntr advances; o_data_valid = 1 for that cycle only.
  - Without rd_ok, o_data holds its value and o_data_valid = 0.
- Read-during-write to the same slot (full buffer, simultaneous rd_ok/wr_ok with wrPntr == rdPntr): the window returns the old RAM contents.
- Errors:
  - i_data_valid && !wr_ok sets o_overflow; the pixel is dropped and wrPntr is unchanged.
  - i_rd_data && !rd_ok sets o_underflow; rdPntr is unchanged and no o_data_valid pulse occurs.
  - Flags stay set until i_clr_flags or reset.
  - If i_clr_flags and a new error occur in the same cycle, the flag is set (set wins).
- Reset mid-operation: all state is discarded immediately; a pending o_data_valid is squashed; the next line starts at slot 0.
- Outputs o_wr_ready, o_rd_ready, o_count and o_line_ready are derived from registered state only; there is no combinational path from i_* inputs.

Test Plan:
1. Reset check (LINE_LEN=8, TAPS=3, DATA_W=8): assert i_rst asynchronously mid-cycle -> all outputs 0 immediately; o_wr_ready=1; o_rd_ready=0.
2. Fill and window: write 0x10..0x17 -> o_count=8, o_line_ready=1, o_wr_ready=0. Read at rdPntr=0 -> next cycle o_data=0x101112 with o_data_valid=1 for one cycle; o_count=7.
3. Edge handling, EDGE_MODE=0: reads at rdPntr=5,6,7 -> 0x151617, 0x161717, 0x171717. Repeat with EDGE_MODE=1 -> 0x161700 and 0x170000 at 6 and 7. rdPntr then wraps to 0.
4. Full with simultaneous read+write: count=8, write 0xAA with a read at rdPntr=0 -> o_data=0x101112 (old data), count stays 8, RAM[0]=0xAA, no overflow.
5. Errors:
   - Write at count=8 with no read -> o_overflow=1, data dropped.
   - Read with count=2 at rdPntr=0 -> o_underflow=1, no valid pulse.
   - i_clr_flags -> both flags 0.
6. Reset during streaming: assert i_rst between a read request and its valid cycle -> no o_data_valid. A refill then returns the first window from slot 0.
